// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic skew feeder.
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} feed_state_e;

  function automatic int beat_total(input int n, input int k);
    return k + n - 1;
  endfunction

  function automatic int default_drain(input int n);
    return 2 * n - 2;
  endfunction

  // Wide enough for the beat counter and the drain counter up to the done edge.
  function automatic int cnt_width(input int n, input int k, input int drain);
    return $clog2(k + n + drain + 1);
  endfunction

endpackage

// File: rtl/skew_lane_mux.sv
// One lane of the diagonal skew: picks elems[beat-LANE] while beat sits inside
// the lane's K-beat window, otherwise drives a zero pad with vld low.
module skew_lane_mux
  import systolic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K     = 3,
  parameter int LANE  = 0,
  parameter int CW    = 4
) (
  input  logic        [CW-1:0]    beat,
  input  logic signed [WIDTH-1:0] elems [K],
  output logic signed [WIDTH-1:0] data,
  output logic                    vld
);

  int beat_i;

  // Compare in int so the lower window edge never wraps (beat >= LANE, not beat-LANE >= 0).
  always_comb begin
    beat_i = int'(beat);
    vld    = (beat_i >= LANE) && (beat_i <= LANE + K - 1);
    data   = '0;
    for (int k = 0; k < K; k++) begin
      if (beat_i == LANE + k) data = elems[k];
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Feeds an N-lane output-stationary systolic array with diagonally skewed rows of A
// (west edge) and columns of B (north edge), followed by a zero drain phase.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 3,
  parameter int K     = 3,
  parameter int DRAIN = default_drain(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] matrixA [N][K],
  input  logic signed [WIDTH-1:0] matrixB [K][N],
  output logic signed [WIDTH-1:0] row [N],
  output logic signed [WIDTH-1:0] col [N],
  output logic        [N-1:0]     lane_vld,
  output logic                    busy,
  output logic                    done
);

  // state | meaning
  // IDLE  | outputs zero, waiting for start; done may be high for one cycle here
  // FEED  | one skewed beat registered per enabled edge, beat_q = next beat index
  // DRAIN | zero beats while partial sums propagate, drain_q = zero beats issued
  // The DRAIN parameter shadows the enum label, so the state is written with its package scope.

  localparam int              CW         = cnt_width(N, K, DRAIN);
  localparam logic [CW-1:0]   BEAT_LAST  = CW'(beat_total(N, K) - 1);
  localparam logic [CW-1:0]   DRAIN_LAST = CW'(DRAIN);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);

  feed_state_e state_q, state_d;

  logic [CW-1:0] beat_q, beat_d;
  logic [CW-1:0] drain_q, drain_d;
  logic          capture;

  logic signed [WIDTH-1:0] abuf [N][K];
  logic signed [WIDTH-1:0] bbuf [K][N];

  logic signed [WIDTH-1:0] row_mux [N];
  logic signed [WIDTH-1:0] col_mux [N];
  logic        [N-1:0]     row_vld;
  logic        [N-1:0]     col_vld;

  logic signed [WIDTH-1:0] row_d [N];
  logic signed [WIDTH-1:0] col_d [N];
  logic        [N-1:0]     vld_d;
  logic                    busy_d;
  logic                    done_d;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [WIDTH-1:0] a_row [K];
    logic signed [WIDTH-1:0] b_col [K];

    for (genvar k = 0; k < K; k++) begin : g_el
      assign a_row[k] = abuf[i][k];
      assign b_col[k] = bbuf[k][i];
    end

    skew_lane_mux #(.WIDTH(WIDTH), .K(K), .LANE(i), .CW(CW)) u_row_mux (
      .beat  (beat_q),
      .elems (a_row),
      .data  (row_mux[i]),
      .vld   (row_vld[i])
    );

    skew_lane_mux #(.WIDTH(WIDTH), .K(K), .LANE(i), .CW(CW)) u_col_mux (
      .beat  (beat_q),
      .elems (b_col),
      .data  (col_mux[i]),
      .vld   (col_vld[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:                if (start) state_d = FEED;
      FEED:                if (en && beat_q == BEAT_LAST) state_d = systolic_pkg::DRAIN;
      systolic_pkg::DRAIN: if (en && drain_q == DRAIN_LAST) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_comb begin
    row_d   = row;
    col_d   = col;
    vld_d   = lane_vld;
    busy_d  = busy;
    done_d  = 1'b0;
    beat_d  = beat_q;
    drain_d = drain_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        row_d  = '{default: '0};
        col_d  = '{default: '0};
        vld_d  = '0;
        busy_d = 1'b0;
        if (start) begin
          capture = 1'b1;
          beat_d  = '0;
          drain_d = '0;
          busy_d  = 1'b1;
        end
      end
      FEED: begin
        if (en) begin
          row_d   = row_mux;
          col_d   = col_mux;
          vld_d   = row_vld & col_vld;
          beat_d  = beat_q + CNT_ONE;
          drain_d = '0;
        end
      end
      systolic_pkg::DRAIN: begin
        if (en) begin
          row_d = '{default: '0};
          col_d = '{default: '0};
          vld_d = '0;
          if (drain_q == DRAIN_LAST) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            drain_d = drain_q + CNT_ONE;
          end
        end
      end
      default: begin
        row_d  = '{default: '0};
        col_d  = '{default: '0};
        vld_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q   <= '0;
      drain_q  <= '0;
      abuf     <= '{default: '0};
      bbuf     <= '{default: '0};
      row      <= '{default: '0};
      col      <= '{default: '0};
      lane_vld <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      beat_q   <= beat_d;
      drain_q  <= drain_d;
      if (capture) begin
        abuf <= matrixA;
        bbuf <= matrixB;
      end
      row      <= row_d;
      col      <= col_d;
      lane_vld <= vld_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule
